// File: rtl/softmax_pkg.sv
// Shared Q6.10 constants, saturation helper and pipeline stage payloads for the softmax datapath.
package softmax_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned FRAC_W = 10;
    localparam int unsigned WIDE_W = 32;

    localparam logic [DATA_W-1:0] LOG2E    = 16'h05C5;
    localparam logic [DATA_W-1:0] Q610_MAX = 16'h7FFF;
    localparam logic [DATA_W-1:0] Q610_MIN = 16'h8000;
    localparam logic [DATA_W-1:0] Q610_ONE = 16'h0400;

    // Clamp a wide signed intermediate into the signed 16-bit range.
    function automatic logic [DATA_W-1:0] sat16(input logic signed [WIDE_W-1:0] v);
        if (v > 32'sd32767) begin
            return Q610_MAX;
        end else if (v < -32'sd32768) begin
            return Q610_MIN;
        end
        return v[DATA_W-1:0];
    endfunction

    typedef struct packed {
        logic              valid;
        logic              sel_mult;
        logic [DATA_W-1:0] m;
        logic [DATA_W-1:0] x;
    } s1_t;

    typedef struct packed {
        logic              valid;
        logic              sel_mult;
        logic [DATA_W-1:0] diff;
    } s2_t;

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] d;
    } s3_t;

endpackage

// File: rtl/reduction_unit_if.sv
// Sample/result bundle between the softmax controller (master) and the reduction unit (slave).
interface reduction_unit_if;
    import softmax_pkg::*;

    logic              en;
    logic              valid_in;
    logic [DATA_W-1:0] in_0;
    logic [DATA_W-1:0] in_1;
    logic              sel_mux;
    logic              sel_mult;
    logic [DATA_W-1:0] out_0;
    logic [DATA_W-1:0] out_1;
    logic              valid_out;

    modport master (
        output en, valid_in, in_0, in_1, sel_mux, sel_mult,
        input  out_0, out_1, valid_out
    );

    modport slave (
        input  en, valid_in, in_0, in_1, sel_mux, sel_mult,
        output out_0, out_1, valid_out
    );

endinterface

// File: rtl/ru_exp2_approx.sv
// Combinational 2^d approximation: integer part shifts, fraction is linearly interpolated as 1 + f.
module ru_exp2_approx
    import softmax_pkg::*;
(
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] pow_c
);

    logic signed [5:0]  n;
    logic [5:0]         rshift;
    logic [DATA_W-1:0]  p;

    always_comb begin
        n      = 6'($signed(d) >>> FRAC_W);
        rshift = 6'(-n);
        p      = {5'b0, 1'b1, d[FRAC_W-1:0]};
        pow_c  = '0;
        if (n >= 6'sd5) begin
            pow_c = Q610_MAX;
        end else if (n >= 6'sd0) begin
            pow_c = p << n[2:0];
        end else if (n <= -6'sd11) begin
            pow_c = '0;
        end else begin
            pow_c = p >> rshift;
        end
    end

endmodule

// File: rtl/reduction_unit.sv
// Four-stage reduction unit: d = (in_1 - M(in_0)) * K and 2^d, with valid carried alongside the data.
module reduction_unit
    import softmax_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    reduction_unit_if.slave   bus
);

    // Leading-one exponent plus linearly interpolated mantissa; non-positive inputs map to the minimum.
    function automatic logic [DATA_W-1:0] log2_approx(input logic [DATA_W-1:0] x);
        logic [4:0]        k;
        logic [DATA_W-1:0] m;
        logic [FRAC_W-1:0] f;
        k = '0;
        if ($signed(x) <= 16'sd0) begin
            return Q610_MIN;
        end
        for (int i = 0; i < 15; i++) begin
            if (x[i]) k = 5'(i);
        end
        m = x & ~(16'(1) << k);
        if (k >= 5'd10) begin
            f = 10'(m >> (k - 5'd10));
        end else begin
            f = 10'(m << (5'd10 - k));
        end
        return 16'((int'(k) - 10) * 1024 + int'(f));
    endfunction

    s1_t               s1;
    s2_t               s2;
    s3_t               s3;
    logic [DATA_W-1:0] out_0_r;
    logic [DATA_W-1:0] out_1_r;
    logic              valid_out_r;

    logic [DATA_W-1:0]        m_c;
    logic [DATA_W-1:0]        diff_c;
    logic signed [WIDE_W-1:0] prod_c;
    logic [DATA_W-1:0]        d_c;
    logic [DATA_W-1:0]        pow_c;

    always_comb begin
        m_c    = bus.sel_mux ? bus.in_0 : log2_approx(bus.in_0);
        diff_c = sat16(32'($signed(s1.x)) - 32'($signed(s1.m)));
        prod_c = 32'($signed(s2.diff)) * 32'($signed(LOG2E));
        d_c    = s2.sel_mult ? sat16(prod_c >>> FRAC_W) : s2.diff;
    end

    ru_exp2_approx u_exp2 (
        .d     (s3.d),
        .pow_c (pow_c)
    );

    // Every stage, including valid, advances together on en and holds otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1          <= '0;
            s2          <= '0;
            s3          <= '0;
            out_0_r     <= '0;
            out_1_r     <= '0;
            valid_out_r <= 1'b0;
        end else if (bus.en) begin
            s1.valid    <= bus.valid_in;
            s1.sel_mult <= bus.sel_mult;
            s1.m        <= m_c;
            s1.x        <= bus.in_1;
            s2.valid    <= s1.valid;
            s2.sel_mult <= s1.sel_mult;
            s2.diff     <= diff_c;
            s3.valid    <= s2.valid;
            s3.d        <= d_c;
            out_0_r     <= s3.d;
            out_1_r     <= pow_c;
            valid_out_r <= s3.valid;
        end
    end

    assign bus.out_0     = out_0_r;
    assign bus.out_1     = out_1_r;
    assign bus.valid_out = valid_out_r;

endmodule

// File: tb/tb_reduction_unit.sv
// Directed bench for reduction_unit: latency, both softmax passes, stall, back-to-back, saturation, reset.
module tb_reduction_unit;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    reduction_unit_if bus ();

    reduction_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] i0, input logic [15:0] i1,
                         input logic smux, input logic smult);
        bus.valid_in = v;
        bus.in_0     = i0;
        bus.in_1     = i1;
        bus.sel_mux  = smux;
        bus.sel_mult = smult;
    endtask

    // Idle samples: M = 0, diff = 0, so the datapath settles to out_0 = 0, out_1 = 1.0.
    task automatic idle();
        drive(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic check_out(input string tag, input logic v, input logic [15:0] o0,
                             input logic [15:0] o1);
        check({tag, "_valid"}, 16'(bus.valid_out), 16'(v));
        check({tag, "_out0"}, bus.out_0, o0);
        check({tag, "_out1"}, bus.out_1, o1);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst   = 1'b1;
        bus.en = 1'b0;
        idle();
        tick();
        tick();
        check_out("reset", 1'b0, 16'h0000, 16'h0000);
        rst    = 1'b0;
        bus.en = 1'b1;
        for (int i = 0; i < 5; i++) tick();

        // Pass 1: latency of 4 edges, single-cycle valid pulse.
        drive(1'b1, 16'h0909, 16'h0549, 1'b1, 1'b1);
        tick();
        idle();
        tick();
        tick();
        check("p1_early_valid", 16'(bus.valid_out), 16'h0000);
        tick();
        check_out("p1", 1'b1, 16'hFA97, 16'h01A5);
        tick();
        check("p1_pulse_end", 16'(bus.valid_out), 16'h0000);

        // Pass 2: log2 path with bypass multiplier.
        drive(1'b1, 16'h0549, 16'hF8C5, 1'b0, 1'b0);
        tick();
        idle();
        for (int i = 0; i < 3; i++) tick();
        check_out("p2", 1'b1, 16'hF77C, 16'h00EF);
        for (int i = 0; i < 4; i++) tick();

        // Stall three cycles with the sample in stage 2.
        drive(1'b1, 16'h0909, 16'h0549, 1'b1, 1'b1);
        tick();
        idle();
        tick();
        bus.en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_out("stall_hold", 1'b0, 16'h0000, 16'h0400);
        end
        bus.en = 1'b1;
        tick();
        check("stall_early_valid", 16'(bus.valid_out), 16'h0000);
        tick();
        check_out("stall_result", 1'b1, 16'hFA97, 16'h01A5);
        for (int i = 0; i < 3; i++) tick();

        // Back-to-back pass 1 then pass 2, each with its own selects.
        drive(1'b1, 16'h0909, 16'h0549, 1'b1, 1'b1);
        tick();
        drive(1'b1, 16'h0549, 16'hF8C5, 1'b0, 1'b0);
        tick();
        idle();
        tick();
        tick();
        check_out("b2b_first", 1'b1, 16'hFA97, 16'h01A5);
        tick();
        check_out("b2b_second", 1'b1, 16'hF77C, 16'h00EF);
        tick();
        check("b2b_end", 16'(bus.valid_out), 16'h0000);
        for (int i = 0; i < 3; i++) tick();

        // Saturation and boundary samples, issued back-to-back.
        drive(1'b1, 16'h8000, 16'h7FFF, 1'b1, 1'b1);
        tick();
        drive(1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0);
        tick();
        drive(1'b1, 16'h0000, 16'hD000, 1'b1, 1'b0);
        tick();
        drive(1'b1, 16'h1234, 16'h1234, 1'b1, 1'b1);
        tick();
        check_out("sat_max", 1'b1, 16'h7FFF, 16'h7FFF);
        drive(1'b1, 16'h0001, 16'h0000, 1'b0, 1'b0);
        tick();
        check_out("sat_log2_zero", 1'b1, 16'h7FFF, 16'h7FFF);
        drive(1'b1, 16'h0300, 16'h0000, 1'b0, 1'b0);
        tick();
        check_out("exp2_underflow", 1'b1, 16'hD000, 16'h0000);
        idle();
        tick();
        check_out("exp2_zero", 1'b1, 16'h0000, 16'h0400);
        tick();
        check_out("log2_k0", 1'b1, 16'h2800, 16'h7FFF);
        tick();
        check_out("log2_k9", 1'b1, 16'h0200, 16'h0600);
        for (int i = 0; i < 3; i++) tick();

        // Asynchronous reset mid-stream discards in-flight samples.
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) drive(1'b1, 16'h0909, 16'h0549, 1'b1, 1'b1);
            else            drive(1'b1, 16'h0549, 16'hF8C5, 1'b0, 1'b0);
            tick();
            if (i == 3) check_out("pre_reset", 1'b1, 16'hFA97, 16'h01A5);
        end
        #2;
        rst = 1'b1;
        #1;
        check_out("async_reset", 1'b0, 16'h0000, 16'h0000);
        tick();
        rst    = 1'b0;
        bus.en = 1'b0;
        idle();
        tick();
        tick();
        check_out("post_reset_hold", 1'b0, 16'h0000, 16'h0000);
        bus.en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("post_reset_no_valid", 16'(bus.valid_out), 16'h0000);
        end
        drive(1'b1, 16'h0549, 16'hF8C5, 1'b0, 1'b0);
        tick();
        idle();
        for (int i = 0; i < 3; i++) tick();
        check_out("post_reset_new", 1'b1, 16'hF77C, 16'h00EF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
